wb_stage_ext: RTL and testbench
===============================

Name: wb_stage_ext

Overview:
- Parametrised writeback stage. Sits between MEM and the regfile/ID.
- Holds the MEM→WB pipeline register, with stall, bubble and flush handling.
- Drives a regfile write channel with per-byte enables, for LWL/LWR-style partial writes.
- Owns the architectural HI/LO registers and drives the difftest debug outputs.

Parameters:
- DATA_W, 32, regfile/HI/LO data width (multiple of 8).
- ADDR_W, 5, regfile address width.
- BE_W, DATA_W/8, byte-enable width.
- STALL_W, 6, stall bus width.
- STAGE_IDX, 4, this stage's bit in the stall bus; STAGE_IDX+1 is the downstream bit.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  clears the pipeline register (exception/eret).
- stall  in  STALL_W  stall bus; `Stop/`NoStop encoding.
- mem_to_wb_bus  in  WB_IN_W  {valid, pc[31:0], rf_be[BE_W], rf_waddr[ADDR_W], rf_wdata[DATA_W], hi_we, lo_we, hi_wdata[DATA_W], lo_wdata[DATA_W]}.
- wb_to_rf_bus  out  BE_W+ADDR_W+DATA_W  {rf_be, rf_waddr, rf_wdata}.
- wb_to_id_bus  out  BE_W+ADDR_W+DATA_W  same content; forwarding to ID.
- hi_o  out  DATA_W  architectural HI, including WB bypass.
- lo_o  out  DATA_W  architectural LO, including WB bypass.
- retire_cnt  out  32  retired-instruction count (optional feature).
- debug_wb_pc  out  32  pc of the instruction in WB.
- debug_wb_rf_wen  out  BE_W  effective byte enables.
- debug_wb_rf_wnum  out  ADDR_W  write address.
- debug_wb_rf_wdata  out  DATA_W  write data.

Behaviour:
- Pipeline register, with priority evaluated at each posedge clk:
  - rst: register cleared to 0.
  - flush: register cleared to 0.
  - stall[STAGE_IDX]==`Stop && stall[STAGE_IDX+1]==`NoStop: register cleared to 0 (bubble).
  - stall[STAGE_IDX]==`NoStop: register loads mem_to_wb_bus.
  - Otherwise: register holds.
- Flush beats stall. rst beats everything.
- A zeroed register means valid=0, and no write of any kind occurs.
- Effective enables:
  - rf_be_eff = valid && waddr!=0 ? rf_be : 0.
  - Writes to $0 are suppressed at WB.
  - wb_to_rf_bus, wb_to_id_bus and debug_wb_rf_wen all carry rf_be_eff.
  - Data and address pass through unchanged.
- Latency: one cycle from mem_to_wb_bus to all outputs.
- HI/LO registers (sub-module):
  - Reset value 0.
  - On a clock edge with valid && hi_we, HI takes hi_wdata. LO is handled independently with lo_we.
  - HI/LO update even if the stall bus holds the stage: the update is keyed to the latched register contents.
  - While stalled, the held instruction must write only once. The sub-module records "committed" for the held pc and clears it on the next load/bubble/flush.
- HI/LO bypass:
  - hi_o = (valid && hi_we && !committed) ? hi_wdata : HI; lo_o likewise.
  - Bypass is same-cycle combinational.
- Reset values of outputs:
  - All bus/debug outputs 0.
  - hi_o/lo_o 0.
  - retire_cnt 0.
- Simultaneous flush and valid HI write in WB:
  - The instruction already in WB commits; flush only clears what would be loaded next.
  - The current register's HI/LO write occurs on that edge.
- Reset mid-stall: the register and committed flag clear, and no write occurs afterwards.

Optional Feature:
- WB_RETIRE_CNT_EN defined:
  - A 32-bit counter increments once per distinct valid instruction leaving WB, using the same committed guard. Stall holds do not double-count.
  - The counter wraps at 2^32−1 → 0.
  - Cleared by rst, not by flush.
- Not defined: retire_cnt tied to 0 and no counter flops.

Decomposition:
- lib/defines.vh gains `WB_IN_W and `WB_TO_RF_WD, derived from DATA_W/ADDR_W defaults.
- It reuses `StallBus, `Stop and `NoStop.
- Sub-module wb_hilo_regs: HI/LO flops, committed flag, bypass muxing and the retire counter.

Test Plan:
- Reset, then load {valid=1, pc=0xBFC00000, be=4'hF, waddr=5, wdata=0x12345678} with stall=0. Next cycle: debug_wb_rf_wen=F, wnum=5, wdata=0x12345678.
- Same load but waddr=0 → rf_be_eff=0 on all three outputs.
- Apply stall[4]=Stop, stall[5]=NoStop → WB outputs 0 the next cycle (bubble).
- Apply stall[4]=Stop, stall[5]=Stop for 3 cycles with be=4'h3 → outputs held for 3 cycles at be=3.
- Valid instruction with hi_we=1, hi_wdata=0xDEADBEEF:
  - hi_o=0xDEADBEEF in the same cycle via bypass.
  - HI=0xDEADBEEF after the edge.
  - Held under stall, then lo-only write 0x1 → HI unchanged; retire_cnt +1 per distinct instruction (macro on).
- Flush while pipeline register valid with lo_we=1, lo_wdata=0x55: LO=0x55 is written, the next cycle is all-zero, and rst then drives every output to 0.

Source files
------------

// File: rtl/wb_stage_ext_pkg.sv
// Shared constants and width helpers for the writeback stage slice.
// Stall encoding: a set bit in the stall bus means that stage is stopped.
package wb_stage_ext_pkg;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_ADDR_W  = 5;
   localparam int DEF_STALL_W = 6;
   localparam int PC_W        = 32;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   // {valid, pc, rf_be, rf_waddr, rf_wdata, hi_we, lo_we, hi_wdata, lo_wdata}
   function automatic int wb_in_width(input int data_w, input int addr_w);
      return 1 + PC_W + (data_w / 8) + addr_w + data_w + 2 + (2 * data_w);
   endfunction

   // {rf_be, rf_waddr, rf_wdata}
   function automatic int wb_to_rf_width(input int data_w, input int addr_w);
      return (data_w / 8) + addr_w + data_w;
   endfunction

   localparam int WB_IN_W     = wb_in_width(DEF_DATA_W, DEF_ADDR_W);
   localparam int WB_TO_RF_WD = wb_to_rf_width(DEF_DATA_W, DEF_ADDR_W);

endpackage

// File: rtl/wb_stage_ext_if.sv
// MEM->WB input bus and WB->regfile / WB->ID forwarding buses.
// master = upstream/consumer side, slave = the writeback stage.
interface wb_stage_ext_if
   import wb_stage_ext_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) ();

   localparam int IN_W = wb_in_width(DATA_W, ADDR_W);
   localparam int RF_W = wb_to_rf_width(DATA_W, ADDR_W);

   logic [IN_W-1:0] mem_to_wb_bus;
   logic [RF_W-1:0] wb_to_rf_bus;
   logic [RF_W-1:0] wb_to_id_bus;

   modport master (
      output mem_to_wb_bus,
      input  wb_to_rf_bus,
      input  wb_to_id_bus
   );

   modport slave (
      input  mem_to_wb_bus,
      output wb_to_rf_bus,
      output wb_to_id_bus
   );

endinterface

// File: rtl/wb_stage_ext_hilo_regs.sv
// HI/LO architectural registers with single-commit guard and same-cycle bypass.
// Optional retire counter enabled by WB_RETIRE_CNT_EN.
module wb_hilo_regs #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              advance,
   input  logic              valid,
   input  logic              hi_we,
   input  logic              lo_we,
   input  logic [DATA_W-1:0] hi_wdata,
   input  logic [DATA_W-1:0] lo_wdata,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o,
   output logic [31:0]       retire_cnt
);

   logic              committed_r;
   logic              commit_s;
   logic [DATA_W-1:0] hi_r;
   logic [DATA_W-1:0] lo_r;

   // The held instruction commits on its first edge in WB; later held edges are no-ops.
   assign commit_s = valid & ~committed_r;

   // Committed flag: set once the held instruction has written, cleared when the register changes.
   always_ff @(posedge clk) begin
      if (rst) begin
         committed_r <= 1'b0;
      end else if (advance) begin
         committed_r <= 1'b0;
      end else if (valid) begin
         committed_r <= 1'b1;
      end else begin
         committed_r <= committed_r;
      end
   end

   // HI register update.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_r <= {DATA_W{1'b0}};
      end else if (commit_s && hi_we) begin
         hi_r <= hi_wdata;
      end else begin
         hi_r <= hi_r;
      end
   end

   // LO register update, independent of HI.
   always_ff @(posedge clk) begin
      if (rst) begin
         lo_r <= {DATA_W{1'b0}};
      end else if (commit_s && lo_we) begin
         lo_r <= lo_wdata;
      end else begin
         lo_r <= lo_r;
      end
   end

   // Bypass pending writes so readers see the value WB is about to commit.
   always_comb begin
      hi_o = hi_r;
      lo_o = lo_r;
      if (commit_s && hi_we) begin
         hi_o = hi_wdata;
      end else begin
         hi_o = hi_r;
      end
      if (commit_s && lo_we) begin
         lo_o = lo_wdata;
      end else begin
         lo_o = lo_r;
      end
   end

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_cnt_r;

   // Retire counter: one count per distinct valid instruction, wraps naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         retire_cnt_r <= 32'd0;
      end else if (commit_s) begin
         retire_cnt_r <= retire_cnt_r + 32'd1;
      end else begin
         retire_cnt_r <= retire_cnt_r;
      end
   end

   assign retire_cnt = retire_cnt_r;
`else
   assign retire_cnt = 32'd0;
`endif

endmodule

// File: rtl/wb_stage_ext.sv
// Writeback stage: MEM->WB pipeline register, regfile/ID write buses, HI/LO, difftest debug.
// Define WB_RETIRE_CNT_EN to build the retired-instruction counter.
module wb_stage_ext
   import wb_stage_ext_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int BE_W      = DATA_W / 8,
   parameter int STALL_W   = 6,
   parameter int STAGE_IDX = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic [STALL_W-1:0] stall,
   wb_stage_ext_if.slave      bus,
   output logic [DATA_W-1:0]  hi_o,
   output logic [DATA_W-1:0]  lo_o,
   output logic [31:0]        retire_cnt,
   output logic [31:0]        debug_wb_pc,
   output logic [BE_W-1:0]    debug_wb_rf_wen,
   output logic [ADDR_W-1:0]  debug_wb_rf_wnum,
   output logic [DATA_W-1:0]  debug_wb_rf_wdata
);

   localparam int IN_W      = wb_in_width(DATA_W, ADDR_W);
   localparam int LO_LSB    = 0;
   localparam int HI_LSB    = DATA_W;
   localparam int LOWE_POS  = 2 * DATA_W;
   localparam int HIWE_POS  = 2 * DATA_W + 1;
   localparam int WDATA_LSB = 2 * DATA_W + 2;
   localparam int WADDR_LSB = WDATA_LSB + DATA_W;
   localparam int BE_LSB    = WADDR_LSB + ADDR_W;
   localparam int PC_LSB    = BE_LSB + BE_W;
   localparam int VALID_POS = PC_LSB + PC_W;

   logic [IN_W-1:0]   pipe_r;
   logic              load_s;
   logic              bubble_s;
   logic              advance_s;
   logic              valid_s;
   logic [31:0]       pc_s;
   logic [BE_W-1:0]   be_s;
   logic [BE_W-1:0]   be_eff_s;
   logic [ADDR_W-1:0] waddr_s;
   logic [DATA_W-1:0] wdata_s;
   logic              hi_we_s;
   logic              lo_we_s;
   logic [DATA_W-1:0] hi_wdata_s;
   logic [DATA_W-1:0] lo_wdata_s;
   logic              unused_stall_s;

   assign load_s    = (stall[STAGE_IDX] == NO_STOP);
   assign bubble_s  = (stall[STAGE_IDX] == STOP) && (stall[STAGE_IDX+1] == NO_STOP);
   assign advance_s = flush | bubble_s | load_s;

   // Only this stage's bit and the downstream bit matter here.
   assign unused_stall_s = ^stall;

   // Pipeline register: rst > flush > bubble > load > hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_r <= {IN_W{1'b0}};
      end else if (flush) begin
         pipe_r <= {IN_W{1'b0}};
      end else if (bubble_s) begin
         pipe_r <= {IN_W{1'b0}};
      end else if (load_s) begin
         pipe_r <= bus.mem_to_wb_bus;
      end else begin
         pipe_r <= pipe_r;
      end
   end

   assign valid_s    = pipe_r[VALID_POS];
   assign pc_s       = pipe_r[PC_LSB +: PC_W];
   assign be_s       = pipe_r[BE_LSB +: BE_W];
   assign waddr_s    = pipe_r[WADDR_LSB +: ADDR_W];
   assign wdata_s    = pipe_r[WDATA_LSB +: DATA_W];
   assign hi_we_s    = pipe_r[HIWE_POS];
   assign lo_we_s    = pipe_r[LOWE_POS];
   assign hi_wdata_s = pipe_r[HI_LSB +: DATA_W];
   assign lo_wdata_s = pipe_r[LO_LSB +: DATA_W];

   // Effective byte enables: invalid slots and writes to $0 never reach the regfile.
   always_comb begin
      be_eff_s = {BE_W{1'b0}};
      if (valid_s && (waddr_s != {ADDR_W{1'b0}})) begin
         be_eff_s = be_s;
      end else begin
         be_eff_s = {BE_W{1'b0}};
      end
   end

   assign bus.wb_to_rf_bus = {be_eff_s, waddr_s, wdata_s};
   assign bus.wb_to_id_bus = {be_eff_s, waddr_s, wdata_s};

   assign debug_wb_pc       = pc_s;
   assign debug_wb_rf_wen   = be_eff_s;
   assign debug_wb_rf_wnum  = waddr_s;
   assign debug_wb_rf_wdata = wdata_s;

   wb_hilo_regs #(
      .DATA_W (DATA_W)
   ) u_hilo (
      .clk        (clk),
      .rst        (rst),
      .advance    (advance_s),
      .valid      (valid_s),
      .hi_we      (hi_we_s),
      .lo_we      (lo_we_s),
      .hi_wdata   (hi_wdata_s),
      .lo_wdata   (lo_wdata_s),
      .hi_o       (hi_o),
      .lo_o       (lo_o),
      .retire_cnt (retire_cnt)
   );

endmodule

// File: tb/tb_wb_stage_ext.sv
// Directed bench for wb_stage_ext: vector table for single loads, hand sequences for
// bubble, stall hold, HI/LO commit/bypass, flush and reset mid-stall.
module tb_wb_stage_ext;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [5:0]  stall;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic [31:0] retire_cnt;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;

   int n_cmp = 0;
   int n_err = 0;

   wb_stage_ext_if #(.DATA_W(32), .ADDR_W(5)) bus_if ();

   wb_stage_ext dut (
      .clk               (clk),
      .rst               (rst),
      .flush             (flush),
      .stall             (stall),
      .bus               (bus_if),
      .hi_o              (hi_o),
      .lo_o              (lo_o),
      .retire_cnt        (retire_cnt),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_wen   (debug_wb_rf_wen),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [3:0]  be;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [3:0]  exp_wen;
      logic [31:0] exp_retire;
   } vec_t;

   vec_t vecs [6];

   function automatic logic [139:0] pack(input logic valid, input logic [31:0] pc,
                                         input logic [3:0] be, input logic [4:0] waddr,
                                         input logic [31:0] wdata, input logic hi_we,
                                         input logic lo_we, input logic [31:0] hi_wd,
                                         input logic [31:0] lo_wd);
      return {valid, pc, be, waddr, wdata, hi_we, lo_we, hi_wd, lo_wd};
   endfunction

   function automatic logic [31:0] rexp(input logic [31:0] r);
`ifdef WB_RETIRE_CNT_EN
      return r;
`else
      return 32'd0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_wb(input string tag, input logic [31:0] pc, input logic [3:0] wen,
                           input logic [4:0] wnum, input logic [31:0] wdata);
      chk({tag, ".pc"},    64'(debug_wb_pc),       64'(pc));
      chk({tag, ".wen"},   64'(debug_wb_rf_wen),   64'(wen));
      chk({tag, ".wnum"},  64'(debug_wb_rf_wnum),  64'(wnum));
      chk({tag, ".wdata"}, 64'(debug_wb_rf_wdata), 64'(wdata));
      chk({tag, ".rfbus"}, 64'(bus_if.wb_to_rf_bus), 64'({wen, wnum, wdata}));
      chk({tag, ".idbus"}, 64'(bus_if.wb_to_id_bus), 64'({wen, wnum, wdata}));
   endtask

   task automatic check_hl(input string tag, input logic [31:0] hi, input logic [31:0] lo,
                           input logic [31:0] ret);
      chk({tag, ".hi"},     64'(hi_o),       64'(hi));
      chk({tag, ".lo"},     64'(lo_o),       64'(lo));
      chk({tag, ".retire"}, 64'(retire_cnt), 64'(rexp(ret)));
   endtask

   initial begin
      vecs[0] = '{1'b1, 32'hBFC0_0000, 4'hF, 5'd5,  32'h1234_5678, 4'hF, 32'd0};
      vecs[1] = '{1'b1, 32'hBFC0_0004, 4'hF, 5'd0,  32'h1234_5678, 4'h0, 32'd1};
      vecs[2] = '{1'b0, 32'hBFC0_0008, 4'hF, 5'd7,  32'hAAAA_5555, 4'h0, 32'd2};
      vecs[3] = '{1'b1, 32'hBFC0_000C, 4'h3, 5'd31, 32'h0000_BEEF, 4'h3, 32'd2};
      vecs[4] = '{1'b1, 32'hBFC0_0010, 4'hC, 5'd1,  32'hCAFE_0000, 4'hC, 32'd3};
      vecs[5] = '{1'b1, 32'hBFC0_0014, 4'h1, 5'd2,  32'h0000_00FF, 4'h1, 32'd4};

      rst = 1'b1;
      flush = 1'b0;
      stall = 6'b000000;
      bus_if.mem_to_wb_bus = '0;
      tick();
      tick();
      check_wb("reset", 32'd0, 4'h0, 5'd0, 32'd0);
      check_hl("reset", 32'd0, 32'd0, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         bus_if.mem_to_wb_bus = pack(vecs[i].valid, vecs[i].pc, vecs[i].be, vecs[i].waddr,
                                     vecs[i].wdata, 1'b0, 1'b0, 32'd0, 32'd0);
         tick();
         check_wb($sformatf("vec%0d", i), vecs[i].pc, vecs[i].exp_wen, vecs[i].waddr, vecs[i].wdata);
         check_hl($sformatf("vec%0d", i), 32'd0, 32'd0, vecs[i].exp_retire);
      end

      // Bubble: this stage stopped, downstream running.
      stall = 6'b010000;
      tick();
      check_wb("bubble", 32'd0, 4'h0, 5'd0, 32'd0);
      check_hl("bubble", 32'd0, 32'd0, 32'd5);

      // Hold for three cycles; upstream bus changes must be ignored.
      stall = 6'b000000;
      bus_if.mem_to_wb_bus = pack(1'b1, 32'hBFC0_0100, 4'h3, 5'd9, 32'h1111_2222,
                                  1'b0, 1'b0, 32'd0, 32'd0);
      tick();
      check_wb("hold_load", 32'hBFC0_0100, 4'h3, 5'd9, 32'h1111_2222);
      check_hl("hold_load", 32'd0, 32'd0, 32'd5);
      stall = 6'b110000;
      bus_if.mem_to_wb_bus = pack(1'b1, 32'hBFC0_0180, 4'hF, 5'd4, 32'hFFFF_FFFF,
                                  1'b1, 1'b1, 32'h9999_9999, 32'h8888_8888);
      for (int c = 0; c < 3; c++) begin
         tick();
         check_wb($sformatf("hold%0d", c), 32'hBFC0_0100, 4'h3, 5'd9, 32'h1111_2222);
         check_hl($sformatf("hold%0d", c), 32'd0, 32'd0, 32'd6);
      end

      // HI write: bypass in the load cycle, single commit while held.
      stall = 6'b000000;
      bus_if.mem_to_wb_bus = pack(1'b1, 32'hBFC0_0200, 4'hF, 5'd3, 32'd0,
                                  1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0);
      tick();
      check_wb("hi_load", 32'hBFC0_0200, 4'hF, 5'd3, 32'd0);
      check_hl("hi_bypass", 32'hDEAD_BEEF, 32'd0, 32'd6);
      stall = 6'b110000;
      bus_if.mem_to_wb_bus = pack(1'b1, 32'hBFC0_0280, 4'hF, 5'd4, 32'd0,
                                  1'b1, 1'b1, 32'h9999_9999, 32'h7777_7777);
      tick();
      check_hl("hi_held0", 32'hDEAD_BEEF, 32'd0, 32'd7);
      tick();
      check_hl("hi_held1", 32'hDEAD_BEEF, 32'd0, 32'd7);
      stall = 6'b000000;
      bus_if.mem_to_wb_bus = pack(1'b1, 32'hBFC0_0204, 4'hF, 5'd4, 32'd0,
                                  1'b0, 1'b1, 32'd0, 32'h0000_0001);
      tick();
      check_hl("lo_only", 32'hDEAD_BEEF, 32'h0000_0001, 32'd7);
      bus_if.mem_to_wb_bus = '0;
      tick();
      check_wb("drain", 32'd0, 4'h0, 5'd0, 32'd0);
      check_hl("drain", 32'hDEAD_BEEF, 32'h0000_0001, 32'd8);

      // Flush with a valid LO write in WB: the write lands, next slot is empty.
      bus_if.mem_to_wb_bus = pack(1'b1, 32'hBFC0_0300, 4'hF, 5'd6, 32'h0000_0077,
                                  1'b0, 1'b1, 32'd0, 32'h0000_0055);
      tick();
      check_hl("flush_load", 32'hDEAD_BEEF, 32'h0000_0055, 32'd8);
      flush = 1'b1;
      bus_if.mem_to_wb_bus = pack(1'b1, 32'hBFC0_0304, 4'hF, 5'd8, 32'h0000_0088,
                                  1'b0, 1'b1, 32'd0, 32'h0000_00AA);
      tick();
      check_wb("flush", 32'd0, 4'h0, 5'd0, 32'd0);
      check_hl("flush", 32'hDEAD_BEEF, 32'h0000_0055, 32'd9);
      flush = 1'b0;
      bus_if.mem_to_wb_bus = '0;
      tick();
      check_wb("post_flush", 32'd0, 4'h0, 5'd0, 32'd0);
      check_hl("post_flush", 32'hDEAD_BEEF, 32'h0000_0055, 32'd9);

      // Flush beats a full stall.
      bus_if.mem_to_wb_bus = pack(1'b1, 32'hBFC0_0400, 4'hF, 5'd10, 32'h0000_0001,
                                  1'b0, 1'b0, 32'd0, 32'd0);
      tick();
      check_wb("fs_load", 32'hBFC0_0400, 4'hF, 5'd10, 32'h0000_0001);
      stall = 6'b110000;
      flush = 1'b1;
      tick();
      check_wb("flush_stall", 32'd0, 4'h0, 5'd0, 32'd0);
      check_hl("flush_stall", 32'hDEAD_BEEF, 32'h0000_0055, 32'd10);
      flush = 1'b0;
      stall = 6'b000000;

      // Reset while a pending HI/LO write is held under stall.
      bus_if.mem_to_wb_bus = pack(1'b1, 32'hBFC0_0500, 4'hF, 5'd11, 32'h0000_0005,
                                  1'b1, 1'b1, 32'h1212_1212, 32'h3434_3434);
      tick();
      check_hl("rst_load", 32'h1212_1212, 32'h3434_3434, 32'd10);
      stall = 6'b110000;
      rst = 1'b1;
      tick();
      check_wb("rst_stall", 32'd0, 4'h0, 5'd0, 32'd0);
      check_hl("rst_stall", 32'd0, 32'd0, 32'd0);
      rst = 1'b0;
      tick();
      check_wb("after_rst", 32'd0, 4'h0, 5'd0, 32'd0);
      check_hl("after_rst", 32'd0, 32'd0, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
